prog_loader: RTL

Byte-stream program loader that writes the 16-bit instruction memory read by the single-cycle datapath.
- Receives a framed program over a valid/ready byte interface.
- Assembles big-endian 16-bit words and writes them sequentially from address 0.
- Holds the processor in reset until a frame loads with a correct checksum.

---
 rtl/prog_loader_pkg.sv | 7 +
 rtl/prog_loader_if.sv | 12 +
 rtl/prog_loader.sv | 81 ++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and widths for the byte-stream program loader
package prog_loader_pkg;
    localparam int IMEM_DEPTH = 16;
    localparam int INSTR_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, CSUM, DONE, ERR} state_e;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: incoming byte stream plus instruction-memory write port
interface prog_loader_if #(parameter int ADDR_W = 4);
    import prog_loader_pkg::*;
    logic [BYTE_W-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    modport master (output in_data, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave (input in_data, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a checksummed frame of big-endian words into imem and gates cpu reset
module prog_loader import prog_loader_pkg::*; #(parameter int ADDR_W = 4) (
    input logic clk,
    input logic reset,
    prog_loader_if.slave bus,
    output logic cpu_hold,
    output logic done,
    output logic err,
    output logic [ADDR_W:0] words_loaded
);
    state_e state_q, state_d;
    logic [ADDR_W:0] n_q, n_d, idx_q, idx_d, idx_inc;
    logic [BYTE_W-1:0] hi_q, hi_d, csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic hs, n_ok;
    always_comb begin
        bus.in_ready = reset && state_q != WRITE;
        bus.imem_we = state_q == WRITE;
        bus.imem_addr = addr_q;
        bus.imem_wdata = wdata_q;
        cpu_hold = state_q != DONE;
        done = state_q == DONE;
        err = state_q == ERR;
        words_loaded = idx_q;
        hs = bus.in_valid && bus.in_ready;
        n_ok = bus.in_data != '0 && 32'(bus.in_data) <= 2 ** ADDR_W;
        idx_inc = idx_q + 1'b1;
        state_d = state_q;
        n_d = n_q;
        idx_d = idx_q;
        hi_d = hi_q;
        csum_d = csum_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: if (hs) begin
                n_d = bus.in_data[ADDR_W:0];
                idx_d = '0;
                csum_d = '0;
                state_d = n_ok ? HI : ERR;
            end
            HI: if (hs) begin
                hi_d = bus.in_data;
                csum_d = csum_q ^ bus.in_data;
                state_d = LO;
            end
            LO: if (hs) begin
                csum_d = csum_q ^ bus.in_data;
                addr_d = idx_q[ADDR_W-1:0];
                wdata_d = {hi_q, bus.in_data};
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_inc;
                state_d = idx_inc == n_q ? CSUM : HI;
            end
            CSUM: if (hs) state_d = bus.in_data == csum_q ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q <= '0;
            idx_q <= '0;
            hi_q <= '0;
            csum_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            idx_q <= idx_d;
            hi_q <= hi_d;
            csum_q <= csum_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule
